// File: rtl/mesh_audio_pkg.sv
// Shared widths, PCM type and node-to-PCM conversion for the mesh audio transmitter.
// Define MESH_AUDIO_SAT_EN to build the x2-gain saturating conversion instead of plain truncation.
package mesh_audio_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned WORD_BITS  = 16;
    localparam int unsigned PCM_W      = 16;
    localparam int unsigned NODE_W     = 18;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int unsigned WORD_IDX_W = $clog2(WORD_BITS);
    localparam int unsigned UFLOW_W    = 8;

    typedef logic [PCM_W-1:0] pcm_t;

    // 2.16 node displacement to 16-bit PCM; the saturating variant keeps one more fraction bit.
    function automatic pcm_t node_to_pcm(input logic [NODE_W-1:0] s);
`ifdef MESH_AUDIO_SAT_EN
        pcm_t r;
        if (s[NODE_W-1] != s[NODE_W-2]) begin
            r = s[NODE_W-1] ? 16'h8000 : 16'h7FFF;
        end else begin
            r = s[NODE_W-2:1];
        end
        return r;
`else
        return s[NODE_W-1:2];
`endif
    endfunction

endpackage

// File: rtl/mesh_audio_tx_sample_fifo.sv
// Synchronous sample FIFO with registered full/empty flags; pop on empty is ignored.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_count_nxt;

    // Push is gated by the pre-pop full flag, so a full FIFO never accepts.
    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset: it is only read while the FIFO holds data.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mesh_audio_tx.sv
// I2S transmitter for mesh node samples: FIFO, bclk/lrck generation, frame shifter, underflow count.
// Conversion gain/saturation selected at build time by MESH_AUDIO_SAT_EN (see mesh_audio_pkg).
module mesh_audio_tx
    import mesh_audio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NODE_W-1:0]  sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               bclk,
    output logic               lrck,
    output logic               sdata,
    output logic [UFLOW_W-1:0] underflow_cnt
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]      r_div;
    logic                  r_bclk;
    logic                  r_lrck;
    logic                  r_sdata;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    pcm_t                  r_frame;
    logic [UFLOW_W-1:0]    r_uflow;

    logic                  w_div_wrap;
    logic                  w_bclk_fall;
    logic                  w_frame_start;
    logic [BIT_CNT_W-1:0]  w_bit_nxt;
    logic [WORD_IDX_W-1:0] w_bit_idx;
    logic                  w_full;
    logic                  w_empty;
    pcm_t                  w_pcm_in;
    pcm_t                  w_head;
    pcm_t                  w_frame_nxt;

    assign w_pcm_in = node_to_pcm(sample_in);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PCM_W)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (sample_valid),
        .i_wdata (w_pcm_in),
        .i_pop   (w_frame_start),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_div_wrap    = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_bclk_fall   = w_div_wrap && r_bclk;
    assign w_bit_nxt     = r_bit_cnt + BIT_CNT_W'(1);
    assign w_frame_start = w_bclk_fall && (w_bit_nxt == '0);
    // MSB-first within each 16-bit word: index is 15 - (bit mod 16).
    assign w_bit_idx     = ~w_bit_nxt[WORD_IDX_W-1:0];
    // On an empty FIFO the previous frame is repeated.
    assign w_frame_nxt   = (w_frame_start && !w_empty) ? w_head : r_frame;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= '1;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
            r_frame   <= '0;
            r_uflow   <= '0;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            // Serial outputs only move with the bclk falling edge.
            if (w_bclk_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_frame   <= w_frame_nxt;
                r_sdata   <= w_frame_nxt[w_bit_idx];
                if (w_bit_nxt == BIT_CNT_W'(WORD_BITS - 1)) begin
                    r_lrck <= 1'b1;
                end else if (w_bit_nxt == BIT_CNT_W'(FRAME_BITS - 1)) begin
                    r_lrck <= 1'b0;
                end
            end
            if (w_frame_start && w_empty && (r_uflow != '1)) begin
                r_uflow <= r_uflow + UFLOW_W'(1);
            end
        end
    end

    assign sample_ready  = !w_full;
    assign bclk          = r_bclk;
    assign lrck          = r_lrck;
    assign sdata         = r_sdata;
    assign underflow_cnt = r_uflow;

endmodule

// File: tb/tb_mesh_audio_tx.sv
// Self-checking bench for mesh_audio_tx: I2S receiver, queue-based reference model, vector table.
module tb_mesh_audio_tx;
    import mesh_audio_pkg::*;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BCLK_PER   = 2 * CLK_DIV;
    localparam int unsigned FRAME_CLKS = 64 * CLK_DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [7:0]  underflow_cnt;

    int checks = 0;
    int errors = 0;

    mesh_audio_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .bclk          (bclk),
        .lrck          (lrck),
        .sdata         (sdata),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conversion computed arithmetically: floor(v/4), or floor(v/2) clamped to int16.
    function automatic logic [15:0] ref_pcm(input logic [17:0] s);
        int v;
        int q;
        v = int'($signed(s));
`ifdef MESH_AUDIO_SAT_EN
        q = v >>> 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`else
        q = v >>> 2;
`endif
        return 16'(q);
    endfunction

    // Reference model: sample queue, frame value, underflow count, expected word stream.
    logic [15:0] m_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] m_frame = '0;
    int m_uflow  = 0;
    int m_c      = 0;
    int m_frames = 0;
    int m_bit    = 31;

    initial forever begin : model
        bit acc;
        bit start;
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_frame  = '0;
            m_uflow  = 0;
            m_c      = 0;
            m_frames = 0;
            m_bit    = 31;
        end else begin
            m_c++;
            acc   = sample_valid && (m_q.size() < FIFO_DEPTH);
            start = 1'b0;
            if (m_c % BCLK_PER == 0) begin
                m_bit = ((m_c / BCLK_PER) - 1) % 32;
                start = (m_bit == 0);
            end
            if (start) begin
                if (m_q.size() > 0) m_frame = m_q.pop_front();
                else if (m_uflow < 255) m_uflow++;
                exp_q.push_back(m_frame);
                exp_q.push_back(m_frame);
                m_frames++;
            end
            if (acc) m_q.push_back(ref_pcm(sample_in));
        end
    end

    // I2S receiver and timing monitor, sampling away from the active edge.
    logic [15:0] rx_q[$];
    logic        p_bclk = 1'b0;
    logic        p_lrck = 1'b0;
    logic        p_sdata = 1'b0;
    logic        p_rx_lrck = 1'b0;
    logic [15:0] rx_sh = '0;
    int          rx_nbits = 0;
    int          since_rise = -1;
    bit          seen_change = 1'b0;

    initial forever begin : monitor
        @(negedge clock);
        if (!reset) begin
            p_bclk = 1'b0; p_lrck = 1'b0; p_sdata = 1'b0; p_rx_lrck = 1'b0;
            rx_sh = '0; rx_nbits = 0; since_rise = -1; seen_change = 1'b0;
        end else begin
            check("ready", 32'(sample_ready), 32'(m_q.size() < FIFO_DEPTH));
            check("uflow", 32'(underflow_cnt), 32'(m_uflow));
            if (sdata !== p_sdata || lrck !== p_lrck)
                check("edge_align", {30'd0, p_bclk, bclk}, 32'd2);
            if (bclk && !p_bclk) begin
                if (since_rise >= 0) check("bclk_period", 32'(since_rise), 32'(BCLK_PER));
                since_rise = 0;
                rx_sh = {rx_sh[14:0], sdata};
                rx_nbits++;
                if (lrck !== p_rx_lrck) begin
                    if (seen_change) check("word_len", 32'(rx_nbits), 32'd16);
                    if (rx_nbits >= 16) begin
                        check("rx_exp_avail", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) check("rx_word", 32'(rx_sh), 32'(exp_q.pop_front()));
                        rx_q.push_back(rx_sh);
                    end
                    seen_change = 1'b1;
                    rx_nbits = 0;
                end
                p_rx_lrck = lrck;
            end
            if (since_rise >= 0) since_rise++;
            p_bclk  = bclk;
            p_lrck  = lrck;
            p_sdata = sdata;
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int guard;
        target = m_frames + n;
        guard  = 0;
        while (m_frames < target && guard < (n + 2) * int'(FRAME_CLKS)) begin
            @(negedge clock);
            guard++;
        end
        if (m_frames < target) check("frame_timeout", 32'(m_frames), 32'(target));
    endtask

    task automatic push_one(input logic [17:0] d);
        @(negedge clock);
        sample_valid = 1'b1;
        sample_in    = d;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},  32'(bclk), 32'd0);
        check({tag, "_lrck"},  32'(lrck), 32'd0);
        check({tag, "_sdata"}, 32'(sdata), 32'd0);
        check({tag, "_ready"}, 32'(sample_ready), 32'd1);
        check({tag, "_uflow"}, 32'(underflow_cnt), 32'd0);
    endtask

    typedef struct {
        logic [17:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc;
        int guard;
`ifdef MESH_AUDIO_SAT_EN
        vecs[0] = '{18'h3FFFF, 16'hFFFF};
        vecs[1] = '{18'h12345, 16'h7FFF};
        vecs[2] = '{18'h10000, 16'h7FFF};
        vecs[3] = '{18'h20000, 16'h8000};
        vecs[4] = '{18'h1FFFF, 16'h7FFF};
        vecs[5] = '{18'h00000, 16'h0000};
`else
        vecs[0] = '{18'h3FFFF, 16'hFFFF};
        vecs[1] = '{18'h12345, 16'h48D1};
        vecs[2] = '{18'h10000, 16'h4000};
        vecs[3] = '{18'h20000, 16'h8000};
        vecs[4] = '{18'h1FFFF, 16'h7FFF};
        vecs[5] = '{18'h00000, 16'h0000};
`endif
        #3 reset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Three starved frames: zeros on the wire and three underflows.
        wait_frames(3);
        check("uflow_after_3", 32'(underflow_cnt), 32'd3);

        // Vector table: each sample must appear on both words of the following frame.
        for (int i = 0; i < 6; i++) begin
            push_one(vecs[i].din);
            wait_frames(1);
            rx_q.delete();
            guard = 0;
            while (rx_q.size() < 2 && guard < 2 * int'(FRAME_CLKS)) begin
                @(negedge clock);
                guard++;
            end
            check("vec_rx_count", 32'(rx_q.size()), 32'd2);
            if (rx_q.size() >= 2) begin
                check("vec_left",  32'(rx_q[0]), 32'(vecs[i].exp));
                check("vec_right", 32'(rx_q[1]), 32'(vecs[i].exp));
            end
        end

        // Full FIFO: hold valid across one pop; exactly one slot reopens.
        wait_frames(1);
        acc = 0;
        for (int k = 0; k < int'(FRAME_CLKS) + 20; k++) begin
            @(negedge clock);
            sample_valid = 1'b1;
            sample_in    = 18'((k + 1) * 4);
            if (k == 4) check("full_ready_low", 32'(sample_ready), 32'd0);
            if (sample_ready) acc++;
        end
        @(negedge clock);
        sample_valid = 1'b0;
        check("full_accepts", 32'(acc), 32'd5);
        wait_frames(6);

        // Randomized traffic with varying push density.
        for (int seg = 0; seg < 6; seg++) begin
            int rate;
            rate = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 3 : 60);
            for (int i = 0; i < 500; i++) begin
                @(negedge clock);
                sample_valid = ($urandom_range(0, 99) < rate);
                sample_in    = 18'($urandom);
            end
        end
        @(negedge clock);
        sample_valid = 1'b0;
        wait_frames(6);

        // Reset at bit 20 with queued samples: everything clears, first frame underflows.
        push_one(18'h0ABCD);
        push_one(18'h15555);
        guard = 0;
        while (m_bit != 20 && guard < 2 * int'(FRAME_CLKS)) begin
            @(negedge clock);
            guard++;
        end
        check("reach_bit20", 32'(m_bit), 32'd20);
        #1 reset = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_frames(1);
        check("mid_uflow", 32'(underflow_cnt), 32'd1);

        // Long starvation: counter saturates at 255.
        wait_frames(256);
        check("uflow_sat", 32'(underflow_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
